// File: rtl/lcd_pkg.sv
// Shared constants, opcode decode and address-counter helpers for the LCD bus receiver.
// Latency: none, these are pure combinational helpers.
// Backpressure: not applicable.
package lcd_pkg;

  localparam logic [7:0] SPACE         = 8'h20;
  localparam logic [6:0] LINE0_BASE    = 7'h00;
  localparam logic [6:0] LINE1_BASE    = 7'h40;
  localparam logic [6:0] LINE_LAST_COL = 7'h27;
  localparam logic [6:0] LINE1_LAST    = LINE1_BASE + LINE_LAST_COL;

  // Instruction opcodes as {mask, value}. The highest set bit selects the instruction.
  localparam logic [7:0] OP_CLEAR_MASK   = 8'hFF, OP_CLEAR_VAL   = 8'h01;
  localparam logic [7:0] OP_HOME_MASK    = 8'hFE, OP_HOME_VAL    = 8'h02;
  localparam logic [7:0] OP_ENTRY_MASK   = 8'hFC, OP_ENTRY_VAL   = 8'h04;
  localparam logic [7:0] OP_DISPCTL_MASK = 8'hF8, OP_DISPCTL_VAL = 8'h08;
  localparam logic [7:0] OP_SHIFT_MASK   = 8'hF0, OP_SHIFT_VAL   = 8'h10;
  localparam logic [7:0] OP_FUNCSET_MASK = 8'hE0, OP_FUNCSET_VAL = 8'h20;
  localparam logic [7:0] OP_CGRAM_MASK   = 8'hC0, OP_CGRAM_VAL   = 8'h40;
  localparam logic [7:0] OP_DDRAM_MASK   = 8'h80, OP_DDRAM_VAL   = 8'h80;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_t;

  function automatic logic op_is(input logic [7:0] b, input logic [7:0] mask,
                                 input logic [7:0] val);
    return (b & mask) == val;
  endfunction

  // Address counter increment with the two-line wrap (0x27->0x40, 0x67->0x00).
  function automatic logic [6:0] ac_inc(input logic [6:0] ac);
    if (ac == LINE_LAST_COL) return LINE1_BASE;
    if (ac == LINE1_LAST)    return LINE0_BASE;
    return ac + 7'd1;
  endfunction

  // Address counter decrement with the two-line wrap (0x00->0x67, 0x40->0x27).
  function automatic logic [6:0] ac_dec(input logic [6:0] ac);
    if (ac == LINE0_BASE) return LINE1_LAST;
    if (ac == LINE1_BASE) return LINE_LAST_COL;
    return ac - 7'd1;
  endfunction

  function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
    return inc ? ac_inc(ac) : ac_dec(ac);
  endfunction

  // Set-DDRAM target: holes past column 0x27 snap to the start of the other line.
  function automatic logic [6:0] ddram_map(input logic [6:0] a);
    if (a[5:0] > 6'h27) return a[6] ? LINE0_BASE : LINE1_BASE;
    return a;
  endfunction

endpackage

// File: rtl/lcd_ddram.sv
// Character buffer RAM: port A read/write for the bus and clear, port B read-only for the consumer.
// Latency: both ports register their read data, 1 clk; port A returns the old byte on a same-address write.
// Backpressure: none, every port accepts an access every cycle.
module lcd_ddram #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [7:0]    a_wdata,
  output logic [7:0]    a_rdata,
  input  logic [AW-1:0] b_addr,
  output logic [7:0]    b_rdata
);

  logic [7:0] mem [DEPTH];

  // Port A: write plus read-before-write registered read.
  always_ff @(posedge clk) begin
    if (a_we) mem[a_addr] <= a_wdata;
    a_rdata <= mem[a_addr];
  end

  // Port B: consumer registered read.
  always_ff @(posedge clk) begin
    b_rdata <= mem[b_addr];
  end

endmodule

// File: rtl/lcd_bus_receiver.sv
// Display end of an 8-bit HD44780-style bus: decodes writes into a 2-line buffer and serves read cycles.
// Latency: pin E edge to state update/cmd_valid/oe is SYNC_STAGES+1 clk; read data 1 clk after oe.
// Backpressure: while busy (clear) writes and RS=1 reads are dropped and flagged; RS=0 reads are always served.
module lcd_bus_receiver
  import lcd_pkg::*;
#(
  parameter int VIS_COLS    = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       lcd_e,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [7:0] lcd_data_in,
  output logic [7:0] lcd_data_out,
  output logic       lcd_data_oe,
  input  logic [4:0] disp_addr,
  output logic [7:0] disp_char,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       two_line,
  output logic       font5x10,
  output logic [6:0] cursor_addr,
  output logic       busy,
  output logic       cmd_valid,
  output logic [7:0] cmd_code,
  output logic       cmd_is_data,
  output logic       err_overrun,
  output logic       err_mode
);

  localparam int         DEPTH      = 2 * VIS_COLS;
  localparam int         AW         = $clog2(DEPTH);
  localparam logic [6:0] VIS_COLS_W = 7'(VIS_COLS);

  // Linear buffer index for {line, col}; callers only use it when col is visible.
  function automatic logic [AW-1:0] buf_idx(input logic line, input logic [5:0] col);
    return line ? (AW'(VIS_COLS) + AW'(col)) : AW'(col);
  endfunction

  // ---------------- input synchronizer and E edge detect ----------------
  logic [10:0] sync_q [SYNC_STAGES];
  logic        e_s, rs_s, rw_s, e_d;
  logic [7:0]  data_s;
  logic        e_rise, e_fall;

  // All bus inputs travel through the same pipeline so they stay mutually aligned.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {lcd_e, lcd_rs, lcd_rw, lcd_data_in};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign e_s    = sync_q[SYNC_STAGES-1][10];
  assign rs_s   = sync_q[SYNC_STAGES-1][9];
  assign rw_s   = sync_q[SYNC_STAGES-1][8];
  assign data_s = sync_q[SYNC_STAGES-1][7:0];

  // Delayed copy of synced E for edge detection.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) e_d <= 1'b0;
    else         e_d <= e_s;
  end

  assign e_rise = e_s & ~e_d;
  assign e_fall = ~e_s & e_d;

  // ---------------- bus event qualification ----------------
  logic wr_evt, wr_acc, rd_evt, rd_acc, rd_end, clr_start;
  logic ac_col_ok;

  assign ac_col_ok = {1'b0, cursor_addr[5:0]} < VIS_COLS_W;

  // A falling E ends an active read; otherwise, with RW=0, it strobes a write.
  always_comb begin
    wr_evt    = e_fall & ~lcd_data_oe & ~rw_s;
    wr_acc    = wr_evt & ~busy;
    rd_evt    = e_rise & rw_s;
    rd_acc    = rd_evt & (~busy | ~rs_s);
    rd_end    = e_fall & lcd_data_oe;
    clr_start = wr_acc & ~rs_s & op_is(data_s, OP_CLEAR_MASK, OP_CLEAR_VAL);
  end

  // ---------------- clear sequencer ----------------
  clr_state_t    state_q, state_nxt;
  logic [AW-1:0] clr_cnt;
  logic          clr_done;

  // Reset lands in ST_CLEAR so the buffer is always blanked after power-up.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= ST_CLEAR;
    else         state_q <= state_nxt;
  end

  // Next state and busy flag.
  always_comb begin
    state_nxt = state_q;
    busy      = 1'b0;
    clr_done  = (clr_cnt == AW'(DEPTH - 1));
    case (state_q)
      ST_IDLE:  if (clr_start) state_nxt = ST_CLEAR;
      ST_CLEAR: begin
        busy = 1'b1;
        if (clr_done) state_nxt = ST_IDLE;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Clear address: one buffer byte per clk while clearing, parked at 0 otherwise.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                                clr_cnt <= '0;
    else if (state_q == ST_CLEAR && !clr_done)  clr_cnt <= clr_cnt + 1'b1;
    else                                        clr_cnt <= '0;
  end

  // ---------------- buffer RAM ----------------
  logic          ram_a_we;
  logic [AW-1:0] ram_a_addr;
  logic [7:0]    ram_a_wdata, ram_a_rdata, ram_b_rdata;
  logic [AW-1:0] disp_idx;
  logic          disp_oob_q;

  // Port A belongs to the clear while busy; otherwise it follows AC for data writes and reads.
  always_comb begin
    ram_a_we    = 1'b0;
    ram_a_addr  = buf_idx(cursor_addr[6], cursor_addr[5:0]);
    ram_a_wdata = data_s;
    if (busy) begin
      ram_a_we    = 1'b1;
      ram_a_addr  = clr_cnt;
      ram_a_wdata = SPACE;
    end else if (wr_acc && rs_s && ac_col_ok) begin
      ram_a_we    = 1'b1;
    end
  end

  assign disp_idx = buf_idx(disp_addr[4], {2'b00, disp_addr[3:0]});

  lcd_ddram #(.DEPTH(DEPTH), .AW(AW)) u_ddram (
    .clk     (clk),
    .a_we    (ram_a_we),
    .a_addr  (ram_a_addr),
    .a_wdata (ram_a_wdata),
    .a_rdata (ram_a_rdata),
    .b_addr  (disp_idx),
    .b_rdata (ram_b_rdata)
  );

  // Consumer columns past the visible width read as blanks, aligned with the RAM latency.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) disp_oob_q <= 1'b0;
    else         disp_oob_q <= ({3'b000, disp_addr[3:0]} >= VIS_COLS_W);
  end

  assign disp_char = disp_oob_q ? SPACE : ram_b_rdata;

  // ---------------- instruction/data execution and read cycles ----------------
  logic entry_inc, entry_shift, rd_rs_q;
  // Entry-mode S bit is stored only; it does not drive any output.
  logic unused_entry_shift;
  assign unused_entry_shift = entry_shift;

  // Architectural state, error flags, write pulse and the read-cycle drive.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cursor_addr  <= LINE0_BASE;
      entry_inc    <= 1'b1;
      entry_shift  <= 1'b0;
      disp_on      <= 1'b0;
      cursor_on    <= 1'b0;
      blink_on     <= 1'b0;
      two_line     <= 1'b0;
      font5x10     <= 1'b0;
      err_overrun  <= 1'b0;
      err_mode     <= 1'b0;
      cmd_valid    <= 1'b0;
      cmd_code     <= 8'h00;
      cmd_is_data  <= 1'b0;
      lcd_data_oe  <= 1'b0;
      lcd_data_out <= 8'h00;
      rd_rs_q      <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      if ((wr_evt && busy) || (rd_evt && busy && rs_s)) err_overrun <= 1'b1;

      if (wr_acc) begin
        cmd_valid   <= 1'b1;
        cmd_code    <= data_s;
        cmd_is_data <= rs_s;
        if (rs_s) begin
          cursor_addr <= ac_step(cursor_addr, entry_inc);
        end else if (op_is(data_s, OP_DDRAM_MASK, OP_DDRAM_VAL)) begin
          cursor_addr <= ddram_map(data_s[6:0]);
        end else if (op_is(data_s, OP_CGRAM_MASK, OP_CGRAM_VAL)) begin
          err_mode <= 1'b1;
        end else if (op_is(data_s, OP_FUNCSET_MASK, OP_FUNCSET_VAL)) begin
          two_line <= data_s[3];
          font5x10 <= data_s[2];
          if (!data_s[4]) err_mode <= 1'b1;
        end else if (op_is(data_s, OP_SHIFT_MASK, OP_SHIFT_VAL)) begin
          if (!data_s[3]) cursor_addr <= ac_step(cursor_addr, data_s[2]);
        end else if (op_is(data_s, OP_DISPCTL_MASK, OP_DISPCTL_VAL)) begin
          disp_on   <= data_s[2];
          cursor_on <= data_s[1];
          blink_on  <= data_s[0];
        end else if (op_is(data_s, OP_ENTRY_MASK, OP_ENTRY_VAL)) begin
          entry_inc   <= data_s[1];
          entry_shift <= data_s[0];
        end else if (op_is(data_s, OP_HOME_MASK, OP_HOME_VAL)) begin
          cursor_addr <= LINE0_BASE;
        end else if (op_is(data_s, OP_CLEAR_MASK, OP_CLEAR_VAL)) begin
          cursor_addr <= LINE0_BASE;
          entry_inc   <= 1'b1;
        end
      end

      if (rd_acc) begin
        lcd_data_oe <= 1'b1;
        rd_rs_q     <= rs_s;
      end else if (rd_end) begin
        lcd_data_oe <= 1'b0;
        if (rd_rs_q) cursor_addr <= ac_step(cursor_addr, entry_inc);
      end

      // Refresh every cycle of the read so status tracks busy live.
      if (lcd_data_oe) begin
        if (rd_rs_q) lcd_data_out <= ac_col_ok ? ram_a_rdata : SPACE;
        else         lcd_data_out <= {busy, cursor_addr};
      end
    end
  end

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Directed bench for lcd_bus_receiver: drives bus cycles and checks state, buffer and read data.
// Latency: expectations sampled well after the SYNC_STAGES+1 clk update.
// Backpressure: exercises writes and reads arriving during a clear.
module tb_lcd_bus_receiver;

  logic       clk = 1'b0;
  logic       resetn;
  logic       lcd_e, lcd_rs, lcd_rw;
  logic [7:0] lcd_data_in, lcd_data_out;
  logic       lcd_data_oe;
  logic [4:0] disp_addr;
  logic [7:0] disp_char;
  logic       disp_on, cursor_on, blink_on, two_line, font5x10;
  logic [6:0] cursor_addr;
  logic       busy, cmd_valid, cmd_is_data, err_overrun, err_mode;
  logic [7:0] cmd_code;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  lcd_bus_receiver #(.VIS_COLS(16), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .lcd_e        (lcd_e),
    .lcd_rs       (lcd_rs),
    .lcd_rw       (lcd_rw),
    .lcd_data_in  (lcd_data_in),
    .lcd_data_out (lcd_data_out),
    .lcd_data_oe  (lcd_data_oe),
    .disp_addr    (disp_addr),
    .disp_char    (disp_char),
    .disp_on      (disp_on),
    .cursor_on    (cursor_on),
    .blink_on     (blink_on),
    .two_line     (two_line),
    .font5x10     (font5x10),
    .cursor_addr  (cursor_addr),
    .busy         (busy),
    .cmd_valid    (cmd_valid),
    .cmd_code     (cmd_code),
    .cmd_is_data  (cmd_is_data),
    .err_overrun  (err_overrun),
    .err_mode     (err_mode)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write cycle; reports clk count from E fall to cmd_valid (0 if none) and the pulse payload.
  task automatic bus_write_m(input logic rs, input logic [7:0] d, output int lat,
                             output logic [7:0] code, output logic isd);
    lcd_rs = rs; lcd_rw = 1'b0; lcd_data_in = d; lcd_e = 1'b1;
    repeat (5) @(negedge clk);
    lcd_e = 1'b0; lat = 0; code = 8'h00; isd = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (cmd_valid && lat == 0) begin
        lat = k; code = cmd_code; isd = cmd_is_data;
      end
    end
    @(negedge clk);
  endtask

  task automatic bus_write(input logic rs, input logic [7:0] d);
    int l; logic [7:0] c; logic i;
    bus_write_m(rs, d, l, c, i);
  endtask

  // Read cycle; oe sampled just after E rises, while E is high, and after E falls.
  task automatic bus_read(input logic rs, output logic [7:0] d, output logic oe_early,
                          output logic oe_hi, output logic oe_lo);
    lcd_rs = rs; lcd_rw = 1'b1; lcd_e = 1'b1;
    @(negedge clk);
    oe_early = lcd_data_oe;
    repeat (4) @(negedge clk);
    d = lcd_data_out; oe_hi = lcd_data_oe;
    lcd_e = 1'b0;
    repeat (6) @(negedge clk);
    oe_lo = lcd_data_oe; lcd_rw = 1'b0;
  endtask

  task automatic disp_rd(input int a, output logic [7:0] c);
    disp_addr = 5'(a);
    @(negedge clk);
    c = disp_char;
  endtask

  // Counts clk edges for which busy stays high, bounded so a stuck busy still ends the run.
  task automatic busy_len(output int n);
    n = 0;
    while (busy && n < 100) begin
      @(posedge clk); #1; n++;
    end
    @(negedge clk);
  endtask

  logic [7:0] msg [6] = '{8'h59, 8'h4F, 8'h55, 8'h20, 8'h57, 8'h49};

  initial begin
    logic [7:0] c, rd, code;
    logic       oe_e, oe_h, oe_l, isd;
    int         n, lat;

    resetn = 1'b0; lcd_e = 1'b0; lcd_rs = 1'b0; lcd_rw = 1'b0;
    lcd_data_in = 8'h00; disp_addr = 5'd0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_oe", lcd_data_oe, 1'b0);
    check("rst_dout", lcd_data_out, 8'h00);
    check("rst_cmd_valid", cmd_valid, 1'b0);
    check("rst_ac", cursor_addr, 7'h00);
    check("rst_flags", {disp_on, cursor_on, blink_on, two_line, font5x10}, 5'b00000);
    check("rst_errs", {err_overrun, err_mode}, 2'b00);

    // Auto-clear after release
    resetn = 1'b1;
    busy_len(n);
    check("auto_clear_len", n, 32);
    for (int i = 0; i < 32; i++) begin
      disp_rd(i, c);
      check($sformatf("blank_%0d", i), c, 8'h20);
    end
    check("ac_after_clear", cursor_addr, 7'h00);

    // Init sequence and "YOU WI"
    bus_write(1'b0, 8'h3C);
    bus_write(1'b0, 8'h0C);
    bus_write(1'b0, 8'h06);
    bus_write(1'b0, 8'h80);
    bus_write_m(1'b1, msg[0], lat, code, isd);
    check("cmd_latency", lat, 3);
    check("cmd_code", code, 8'h59);
    check("cmd_is_data", isd, 1'b1);
    for (int i = 1; i < 6; i++) bus_write(1'b1, msg[i]);
    check("init_flags", {disp_on, cursor_on, blink_on, two_line, font5x10}, 5'b10011);
    check("init_err_mode", err_mode, 1'b0);
    for (int i = 0; i < 6; i++) begin
      disp_rd(i, c);
      check($sformatf("msg_%0d", i), c, msg[i]);
    end
    check("ac_after_msg", cursor_addr, 7'h06);

    // Status read and data read
    bus_read(1'b0, rd, oe_e, oe_h, oe_l);
    check("rd0_data", rd, 8'h06);
    check("rd0_oe_early", oe_e, 1'b0);
    check("rd0_oe_hi", oe_h, 1'b1);
    check("rd0_oe_lo", oe_l, 1'b0);
    bus_write(1'b0, 8'h82);
    bus_read(1'b1, rd, oe_e, oe_h, oe_l);
    check("rd1_data", rd, 8'h55);
    check("rd1_oe_hi", oe_h, 1'b1);
    check("rd1_oe_lo", oe_l, 1'b0);
    check("rd1_ac_adv", cursor_addr, 7'h03);

    // Line 1 fill with 17 bytes
    bus_write(1'b0, 8'hC0);
    for (int i = 0; i < 17; i++) bus_write(1'b1, 8'(8'h61 + i));
    check("l1_ac", cursor_addr, 7'h51);
    disp_rd(16, c); check("l1_col0", c, 8'h61);
    disp_rd(31, c); check("l1_col15", c, 8'h70);
    disp_rd(0, c);  check("l0_untouched", c, 8'h59);

    // Invisible column write and wrap 0x27 -> 0x40
    bus_write(1'b0, 8'hA7);
    check("ac_set_27", cursor_addr, 7'h27);
    bus_write(1'b1, 8'h41);
    check("ac_wrap_40", cursor_addr, 7'h40);
    disp_rd(16, c); check("l1_col0_kept", c, 8'h61);
    disp_rd(5, c);  check("l0_col5_kept", c, 8'h49);

    // Decrement entry and cursor shifts across the 0x00/0x67 wrap
    bus_write(1'b0, 8'h04);
    bus_write(1'b0, 8'h80);
    bus_write(1'b1, 8'h41);
    disp_rd(0, c); check("dec_write", c, 8'h41);
    check("ac_dec_wrap", cursor_addr, 7'h67);
    bus_write(1'b0, 8'h14);
    check("shift_r_wrap", cursor_addr, 7'h00);
    bus_write(1'b0, 8'h10);
    check("shift_l_wrap", cursor_addr, 7'h67);
    bus_write(1'b0, 8'h1C);
    check("disp_shift_noop", cursor_addr, 7'h67);
    bus_write(1'b0, 8'h06);

    // CGRAM address sets err_mode
    bus_write(1'b0, 8'h40);
    check("cgram_err_mode", err_mode, 1'b1);

    // Clear with overlapping traffic
    check("ovr_before", err_overrun, 1'b0);
    bus_write(1'b0, 8'h01);
    check("clear_busy", busy, 1'b1);
    bus_write_m(1'b1, 8'h42, lat, code, isd);
    check("dropped_no_cmd", lat, 0);
    check("ovr_after", err_overrun, 1'b1);
    bus_read(1'b0, rd, oe_e, oe_h, oe_l);
    check("busy_status_rd", rd, 8'h80);
    busy_len(n);
    check("clear_ends", busy, 1'b0);
    check("clear_ac", cursor_addr, 7'h00);
    disp_rd(0, c);  check("clear_col0", c, 8'h20);
    disp_rd(16, c); check("clear_l1_col0", c, 8'h20);

    // Reset mid-read, then reset mid-clear
    lcd_rs = 1'b0; lcd_rw = 1'b1; lcd_e = 1'b1;
    repeat (5) @(negedge clk);
    check("midrd_oe_hi", lcd_data_oe, 1'b1);
    resetn = 1'b0;
    #1;
    check("midrd_oe_rst", lcd_data_oe, 1'b0);
    check("midrd_dout_rst", lcd_data_out, 8'h00);
    lcd_e = 1'b0; lcd_rw = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    repeat (10) @(negedge clk);
    check("midclr_busy", busy, 1'b1);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    busy_len(n);
    check("restart_clear_len", n, 32);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lcd_bus_receiver.md
# lcd_bus_receiver

- Receives the HD44780-style 8-bit parallel LCD bus (E, RS, RW, DATA) that our LCD controllers drive, and behaves as the display end of it.
- Decodes instructions and character writes into a 2×16 character buffer, keeps display/entry/function state, and answers bus read cycles.
- Exposes the buffer on a second read port so an on-chip consumer (VGA/7-seg mirror, bench scoreboard) can render what the controller wrote.

## Interface
- `VIS_COLS`, default 16: visible columns per line; the buffer is 2×VIS_COLS bytes.
- `SYNC_STAGES`, default 2: synchronizer depth on the bus inputs.
- `clk`  in  1  system clock; must be ≥8× the LCD_E frequency.
- `resetn`  in  1  asynchronous, active-low reset.
- `lcd_e`, `lcd_rs`, `lcd_rw`  in  1 each  bus strobe, register select, read/write.
- `lcd_data_in`  in  8  bus data from the controller.
- `lcd_data_out`  out  8  read-cycle data; the pad tri-state lives at top level.
- `lcd_data_oe`  out  1  drive enable for `lcd_data_out`.
- `disp_addr`  in  5  consumer read address, {line, col[3:0]}.
- `disp_char`  out  8  buffer byte at `disp_addr`; registered.
- `disp_on`, `cursor_on`, `blink_on`  out  1 each  display-control flags.
- `two_line`, `font5x10`  out  1 each  function-set N and F bits.
- `cursor_addr`  out  7  address counter AC.
- `busy`  out  1  internal operation (clear) in progress.
- `cmd_valid`  out  1  one-cycle pulse per accepted write; `cmd_code` (8) is the byte, `cmd_is_data` (1) is its RS.
- `err_overrun`, `err_mode`  out  1 each  sticky error flags, cleared only by reset.

## Operation
- Input path: every bus input passes through SYNC_STAGES flops, all aligned in the same pipeline. One more flop gives the edge detector on synced E.
- Write (RW=0) is latched on the synced E falling edge.
  - 0x01 clear: fill all buffer bytes with 0x20 at one per clk; set AC=0 and I/D=1; `busy`=1 for 2×VIS_COLS cycles.
  - 0x02/0x03 return home: AC=0, buffer unchanged.
  - 0b000001DS entry mode: store I/D; S is stored but shift is not implemented.
  - 0b00001DCB: set `disp_on`, `cursor_on`, `blink_on`.
  - 0b0001SRxx: with S/C=0, move AC by ±1 (R/L) using the wrap rules; with S/C=1 (display shift) do nothing.
  - 0b001LNFxx: store N and F. L=0 (4-bit mode) sets `err_mode`, and the bus is still treated as 8-bit.
  - 0b01xxxxxx (CGRAM address): ignored, sets `err_mode`.
  - 0b1aaaaaaa: AC=a. Values 0x28–0x3F map to 0x40; 0x68–0x7F map to 0x00.
  - RS=1 data: write the byte to buffer[line, col] when col=AC[5:0]<VIS_COLS, with line=AC[6]. Otherwise no buffer write. In both cases AC then advances by I/D.
- AC wrap rules:
  - Increment: 0x27→0x40, 0x67→0x00.
  - Decrement: 0x00→0x67, 0x40→0x27.
- Read (RW=1):
  - On the synced E rising edge, assert `lcd_data_oe`.
  - Drive `lcd_data_out` = {busy, AC} for RS=0, or buffer[AC] for RS=1 (0x20 when col ≥ VIS_COLS).
  - On the synced falling edge, deassert oe; an RS=1 read also advances AC.
- Writes or reads arriving while `busy`: dropped, with no AC change and no `cmd_valid`; set `err_overrun`. Exception: an RS=0 read is always served.
- Reset:
  - All flags 0, I/D=1, S=0, AC=0, `lcd_data_oe`=0, `lcd_data_out`=0, `cmd_valid`=0, errors 0.
  - After release, an automatic clear runs with `busy`=1.
  - Reset asserted mid-clear restarts the clear after release.

## Timing
- Pin E edge → `cmd_valid` / state update: SYNC_STAGES+1 clk (3 at default).
- Pin E rise → `lcd_data_oe`: SYNC_STAGES+1 clk. `lcd_data_out` is valid 1 clk later because the buffer read is registered.
- Data setup requirement: DATA/RS/RW stable from E fall until SYNC_STAGES+2 clk after it. Hence clk ≥ 8× E frequency when data changes at the E rising edge.
- `disp_char`: 1-clk latency. On a same-cycle bus write to the same address it returns the old value (read-before-write).
- Clear: `busy` rises the cycle after the 0x01 strobe and stays high exactly 2×VIS_COLS clk.
- Consumer reads during a clear see partially cleared contents.

## Structure
- Package `lcd_pkg` holds:
  - Opcode masks/values (CLEAR, HOME, ENTRY, DISPCTL, SHIFT, FUNCSET, CGRAM, DDRAM).
  - Constants SPACE=8'h20, LINE0_BASE=7'h00, LINE1_BASE=7'h40, LINE_LAST_COL=7'h27.
- Sub-module `lcd_ddram`: 2×VIS_COLS×8 RAM.
  - Port A: bus read/write and clear.
  - Port B: consumer read-only.
  - Both ports registered reads.

## Test plan
- Reset release → `busy`=1 for 32 clk. Afterwards all 32 `disp_char` reads = 0x20, AC=0.
- Controller sequence 0x3C, 0x0C, 0x06, 0x80, then data "YOU WI" → `two_line`=1, `font5x10`=1, `disp_on`=1, `cursor_on`=0. Buffer line 0 col 0..5 = 59 4F 55 20 57 49, AC=0x06.
- 0xC0 then 17 data bytes → line 1 cols 0–15 are written, the 17th byte is not stored, AC=0x51. Separately, 0xA7 then data byte 0x41 → AC=0x40, buffer unchanged.
- Entry 0x04 (decrement), 0x80, data 0x41 → buffer[0,0]=0x41, AC=0x67.
- 0x01 followed by a data write within 32 clk → write dropped, `err_overrun`=1. An RS=0 read during the clear returns 0x80.
- Read cycles: RS=0 returns {0,AC}. RS=1 at AC=0x02 returns buffer byte with `lcd_data_oe` high only while E is high, then AC=0x03. Assert `resetn` mid-read → oe=0 immediately.
